keypad_scanner: RTL and testbench

//  Matrix-keypad receiver: drives keypad rows one at a time (active-low), samples the

---
 rtl/keypad_scanner.sv | 127 ++++++++++++
 tb/tb_keypad_scanner.sv | 126 ++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad receiver (row scan, 2-flop column sync, debounce, valid/ack key delivery)
//   clk       in   rising-edge system clock
//   rst_n     in   asynchronous active-low reset
//   row_n     out  [ROWS] one-hot-low row drive
//   col_n     in   [COLS] column sense, low = closed
//   key_code  out  [KW]   row*COLS+col of accepted key
//   key_valid out  key_code holds an unacknowledged key
//   key_ack   in   consumer accepts key
//   key_held  out  accepted key still held
//   overflow  out  sticky: key accepted while key_valid already set
module keypad_scanner #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEB_CNT = 4,
  localparam int KW = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row_n,
  input  logic [COLS-1:0] col_n,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ack,
  output logic            key_held,
  output logic            overflow
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEB_CNT + 1);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;
  state_t state, state_d;
  logic [COLS-1:0] s1_n, cs_n, pat;
  logic [TW-1:0] cnt;
  logic [RW-1:0] row;
  logic [CW-1:0] col_lo;
  logic [DW-1:0] deb, deb_d, rel, rel_d;
  logic tick, adv, latch, accept;
  logic [KW-1:0] code;
  assign tick = cnt == TW'(SCAN_DIV - 1);
  assign row_n = ~(ROWS'(1) << row);
  assign key_held = state == PRESSED;
  // Row is frozen outside SCAN and the pattern matches at accept, so the live row and
  // lowest low column always identify the accepted key.
  assign code = KW'(int'(row) * COLS + int'(col_lo));
  always_comb begin
    col_lo = '0;
    for (int i = COLS - 1; i >= 0; i--) if (!cs_n[i]) col_lo = CW'(i);
  end
  always_comb begin
    state_d = state;
    deb_d = deb;
    rel_d = rel;
    adv = 1'b0;
    latch = 1'b0;
    accept = 1'b0;
    if (tick)
      case (state)
        SCAN:
          if (&cs_n) adv = 1'b1;
          else begin
            latch = 1'b1;
            deb_d = DW'(1);
            if (DEB_CNT == 1) begin
              accept = 1'b1;
              rel_d = '0;
              state_d = PRESSED;
            end else state_d = DEBOUNCE;
          end
        DEBOUNCE:
          if (cs_n == pat) begin
            deb_d = deb + 1'b1;
            if (deb_d == DW'(DEB_CNT)) begin
              accept = 1'b1;
              rel_d = '0;
              state_d = PRESSED;
            end
          end else begin
            deb_d = '0;
            adv = 1'b1;
            state_d = SCAN;
          end
        PRESSED: begin
          rel_d = &cs_n ? rel + 1'b1 : '0;
          if (rel_d == DW'(DEB_CNT)) begin
            rel_d = '0;
            adv = 1'b1;
            state_d = SCAN;
          end
        end
        default: state_d = SCAN;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SCAN;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_n <= '1;
      cs_n <= '1;
      pat <= '1;
      cnt <= '0;
      row <= '0;
      deb <= '0;
      rel <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s1_n <= col_n;
      cs_n <= s1_n;
      cnt <= tick ? '0 : cnt + 1'b1;
      if (adv) row <= row == RW'(ROWS - 1) ? '0 : row + 1'b1;
      if (latch) pat <= cs_n;
      deb <= deb_d;
      rel <= rel_d;
      // An ack on the accept edge frees the slot, so the new key loads without overflow.
      if (accept) begin
        if (key_valid && !key_ack) overflow <= 1'b1;
        else begin
          key_valid <= 1'b1;
          key_code <= code;
        end
      end else if (key_ack) key_valid <= 1'b0;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;
  logic clk = 1'b0, rst_n = 1'b0, key_ack = 1'b0;
  logic [3:0] row_n, col_n, key_code, exp_row;
  logic key_valid, key_held, overflow, seen;
  logic [15:0] keys = '0;
  int checks = 0, errors = 0, n;
  keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic hit(input int sel);
    return sel == 0 ? key_valid : sel == 1 ? !key_held : sel == 2 ? overflow : row_n == 4'b1101;
  endfunction
  task automatic wait_sig(input string tag, input int sel, input int budget, output int cnt);
    cnt = 0;
    while (!hit(sel) && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    check(tag, 32'(hit(sel)), 1);
  endtask
  task automatic ack;
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_row", row_n, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      check("walk_row", row_n, exp_row);
    end
    check("walk_valid", key_valid, 0);
    keys[9] = 1'b1;
    wait_sig("k9_valid", 0, 200, n);
    check("k9_latency", 32'(n <= 31), 1);
    check("k9_code", key_code, 9);
    check("k9_held", key_held, 1);
    repeat (5) @(negedge clk);
    check("k9_valid_hold", key_valid, 1);
    ack();
    check("k9_ack", key_valid, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= key_valid;
    end
    check("k9_once", seen, 0);
    keys = '0;
    wait_sig("k9_release", 1, 40, n);
    wait_sig("bounce_row1", 3, 40, n);
    keys[7] = 1'b1;
    repeat (8) @(negedge clk);
    keys = '0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      seen |= key_valid | key_held;
    end
    check("bounce_nokey", seen, 0);
    keys[9] = 1'b1;
    wait_sig("ovf_k9_valid", 0, 200, n);
    check("ovf_k9_code", key_code, 9);
    keys = '0;
    wait_sig("ovf_k9_release", 1, 40, n);
    keys[0] = 1'b1;
    wait_sig("ovf_set", 2, 200, n);
    check("ovf_code_kept", key_code, 9);
    check("ovf_valid", key_valid, 1);
    ack();
    check("ovf_ack", key_valid, 0);
    keys = '0;
    wait_sig("ovf_k0_release", 1, 40, n);
    keys[12] = 1'b1;
    keys[14] = 1'b1;
    wait_sig("multi_valid", 0, 200, n);
    check("multi_code", key_code, 12);
    check("multi_held", key_held, 1);
    ack();
    keys = '0;
    repeat (9) @(negedge clk);
    check("multi_held_rel", key_held, 1);
    wait_sig("multi_release", 1, 6, n);
    check("multi_ovf_sticky", overflow, 1);
    wait_sig("rst_row1", 3, 40, n);
    keys[5] = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_row", row_n, 4'b1110);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_held", key_held, 0);
    check("mid_rst_ovf", overflow, 0);
    keys = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_valid", key_valid, 0);
    check("post_rst_ovf", overflow, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
